mc_control_fsm: RTL and testbench

- Multi-cycle control unit for the 32-bit MIPS datapath.
- Consumes the decoded instruction fields and the ALU zero flag from the datapath.
- Sequences fetch/decode/execute/memory/writeback over several cycles, and drives every datapath select, enable and ALU-operation line.
- Stalls on a data-memory ready handshake.

---
 rtl/mc_pkg.sv | 68 ++++++
 rtl/mc_alu_decode.sv | 34 +++
 rtl/mc_control_fsm.sv | 162 ++++++++++++++++
 tb/tb_mc_control_fsm.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: FSM states, instruction
// field encodings, ALU operation codes and the registered control word.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StExecR,
    StWbR,
    StExecI,
    StWbI,
    StMemAddr,
    StMemRd,
    StMemWb,
    StMemWr,
    StBranch,
    StJump,
    StJal,
    StJr
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnJr  = 6'b001000;
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  // Moore part of the outputs; branch/bne/decode qualify the few outputs that
  // also look at live inputs (zero, opcode) in the current cycle.
  typedef struct packed {
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       regsel;
    logic       regdst;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       jal;
    logic       jr;
    logic       jmp;
    logic       branch;
    logic       bne;
    logic       decode;
    logic [2:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational ALU-operation decode from opcode/funct; r_valid_o flags a supported
// arithmetic R-type funct (jr is dispatched separately and is not counted here).
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] opr_i,
  output logic [2:0] aluop_o,
  output logic       r_valid_o
);

  always_comb begin
    aluop_o   = AluAdd;
    r_valid_o = 1'b0;
    case (opcode_i)
      OpRtype: begin
        case (opr_i)
          FnAdd: begin aluop_o = AluAdd; r_valid_o = 1'b1; end
          FnSub: begin aluop_o = AluSub; r_valid_o = 1'b1; end
          FnAnd: begin aluop_o = AluAnd; r_valid_o = 1'b1; end
          FnOr:  begin aluop_o = AluOr;  r_valid_o = 1'b1; end
          FnSlt: begin aluop_o = AluSlt; r_valid_o = 1'b1; end
          default: ;
        endcase
      end
      OpBeq, OpBne: aluop_o = AluSub;
      OpSlti:       aluop_o = AluSlt;
      OpAndi:       aluop_o = AluAnd;
      OpOri:        aluop_o = AluOr;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready with a timeout, and drives all datapath control lines.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] opr,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       regsel,
  output logic       regdst,
  output logic       alusrc,
  output logic       memread,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       pcsrc,
  output logic       jal,
  output logic       jr,
  output logic       jmp,
  output logic [2:0] aluopration,
  output logic       illegal,
  output logic       bus_err
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d, disp_state;
  logic [CntW-1:0] cnt_q, cnt_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic            run_q;
  logic            bus_err_q, bus_err_d;
  logic            disp_legal;
  logic [2:0]      dec_aluop;
  logic            dec_r_valid;
  logic            take;

  mc_alu_decode u_alu_decode (
    .opcode_i  (opcode),
    .opr_i     (opr),
    .aluop_o   (dec_aluop),
    .r_valid_o (dec_r_valid)
  );

  function automatic ctrl_t ctrl_of(state_e st, logic [2:0] op, logic is_bne);
    ctrl_t c;
    c = '0;
    case (st)
      StFetch:   begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.aluop = AluAdd; end
      StDecode:  c.decode = 1'b1;
      StExecR:   c.aluop = op;
      StWbR:     begin c.regdst = 1'b1; c.regwrite = 1'b1; c.aluop = op; end
      StExecI:   begin c.alusrc = 1'b1; c.aluop = op; end
      StWbI:     begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = op; end
      StMemAddr: begin c.alusrc = 1'b1; c.aluop = AluAdd; end
      StMemRd:   c.memread = 1'b1;
      StMemWb:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      StMemWr:   c.memwrite = 1'b1;
      StBranch:  begin c.branch = 1'b1; c.bne = is_bne; c.aluop = AluSub; end
      StJump:    begin c.jmp = 1'b1; c.pcwrite = 1'b1; end
      StJal: begin
        c.jmp      = 1'b1;
        c.pcwrite  = 1'b1;
        c.regsel   = 1'b1;
        c.jal      = 1'b1;
        c.regwrite = 1'b1;
      end
      StJr:      begin c.jmp = 1'b1; c.jr = 1'b1; c.pcwrite = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    disp_state = StFetch;
    disp_legal = 1'b1;
    case (opcode)
      OpRtype: begin
        if (opr == FnJr) disp_state = StJr;
        else if (dec_r_valid) disp_state = StExecR;
        else disp_legal = 1'b0;
      end
      OpLw, OpSw:                    disp_state = StMemAddr;
      OpBeq, OpBne:                  disp_state = StBranch;
      OpAddi, OpSlti, OpAndi, OpOri: disp_state = StExecI;
      OpJ:                           disp_state = StJump;
      OpJal:                         disp_state = StJal;
      default:                       disp_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    bus_err_d = 1'b0;
    unique case (state_q)
      StFetch:   state_d = StDecode;
      StDecode:  state_d = disp_legal ? disp_state : StFetch;
      StExecR:   state_d = StWbR;
      StExecI:   state_d = StWbI;
      StMemAddr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd, StMemWr: begin
        // Ready on the timeout cycle still completes the access.
        if (mem_ready) begin
          state_d = (state_q == StMemRd) ? StMemWb : StFetch;
        end else if (cnt_q == CntLast) begin
          state_d   = StFetch;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWbR, StWbI, StMemWb, StBranch, StJump, StJal, StJr: state_d = StFetch;
      default: state_d = StFetch;
    endcase
    // The first edge after reset performs FETCH rather than advancing past it.
    if (!run_q) state_d = StFetch;
    ctrl_d = ctrl_of(state_d, dec_aluop, opcode == OpBne);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StFetch;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      run_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      run_q     <= 1'b1;
      bus_err_q <= bus_err_d;
    end
  end

  assign take        = ctrl_q.branch & (zero ^ ctrl_q.bne);
  assign irwrite     = ctrl_q.irwrite;
  assign pcwrite     = ctrl_q.pcwrite | take;
  assign regwrite    = ctrl_q.regwrite;
  assign regsel      = ctrl_q.regsel;
  assign regdst      = ctrl_q.regdst;
  assign alusrc      = ctrl_q.alusrc;
  assign memread     = ctrl_q.memread;
  assign memwrite    = ctrl_q.memwrite;
  assign memtoreg    = ctrl_q.memtoreg;
  assign pcsrc       = take;
  assign jal         = ctrl_q.jal;
  assign jr          = ctrl_q.jr;
  assign jmp         = ctrl_q.jmp;
  assign aluopration = ctrl_q.aluop;
  assign illegal     = ctrl_q.decode & ~disp_legal;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expected output words are queued by
// the stimulus process and checked by a negedge monitor.
module tb_mc_control_fsm;

  logic       clk, rst, zero, mem_ready;
  logic [5:0] opcode, opr;
  logic       irwrite, pcwrite, regwrite, regsel, regdst, alusrc;
  logic       memread, memwrite, memtoreg, pcsrc, jal, jr, jmp, illegal, bus_err;
  logic [2:0] aluopration;
  logic [17:0] obs;

  mc_control_fsm #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .opr(opr), .zero(zero), .mem_ready(mem_ready),
    .irwrite(irwrite), .pcwrite(pcwrite), .regwrite(regwrite), .regsel(regsel),
    .regdst(regdst), .alusrc(alusrc), .memread(memread), .memwrite(memwrite),
    .memtoreg(memtoreg), .pcsrc(pcsrc), .jal(jal), .jr(jr), .jmp(jmp),
    .aluopration(aluopration), .illegal(illegal), .bus_err(bus_err)
  );

  assign obs = {irwrite, pcwrite, regwrite, regsel, regdst, alusrc, memread, memwrite,
                memtoreg, pcsrc, jal, jr, jmp, aluopration, illegal, bus_err};

  localparam logic [17:0] IRW  = 18'h20000, PCW  = 18'h10000, RGW  = 18'h08000;
  localparam logic [17:0] RSEL = 18'h04000, RDST = 18'h02000, ASRC = 18'h01000;
  localparam logic [17:0] MRD  = 18'h00800, MWR  = 18'h00400, MTR  = 18'h00200;
  localparam logic [17:0] PSRC = 18'h00100, JALB = 18'h00080, JRB  = 18'h00040;
  localparam logic [17:0] JMPB = 18'h00020, ILL  = 18'h00002, BERR = 18'h00001;
  localparam logic [17:0] OP_ADD = 18'h00008, OP_SUB = 18'h00018, OP_OR = 18'h00004;
  localparam logic [17:0] FETCH_V = IRW | PCW | OP_ADD;

  logic [17:0] sb[$];
  int n_vec = 0;
  int n_err = 0;
  int cycle = 0;

  initial clk = 1'b1;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cycle++;
    if (sb.size() > 0) begin
      logic [17:0] e;
      e = sb.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL outputs cycle %0d: got %h want %h", cycle, obs, e);
      end
    end
  end

  task automatic cyc(input logic [17:0] e, input logic z, input logic mr);
    zero      = z;
    mem_ready = mr;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    opr    = fn;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; opcode = '0; opr = '0; zero = 1'b0; mem_ready = 1'b0;
    cyc('0, 0, 0);
    cyc('0, 0, 0);
    rst = 1'b1;
    cyc('0, 0, 0);

    // add, with stray mem_ready that must be ignored
    instr(6'b000000, 6'b100000);
    cyc(FETCH_V, 0, 1); cyc('0, 0, 1); cyc(OP_ADD, 0, 1); cyc(RGW | RDST | OP_ADD, 0, 1);
    // sub
    instr(6'b000000, 6'b100010);
    cyc(FETCH_V, 0, 0); cyc('0, 0, 0); cyc(OP_SUB, 0, 0); cyc(RGW | RDST | OP_SUB, 0, 0);
    // ori
    instr(6'b001101, 6'b000000);
    cyc(FETCH_V, 0, 0); cyc('0, 0, 0); cyc(ASRC | OP_OR, 0, 0);
    cyc(RGW | ASRC | OP_OR, 0, 0);
    // lw with three wait cycles
    instr(6'b100011, 6'b000000);
    cyc(FETCH_V, 0, 0); cyc('0, 0, 0); cyc(ASRC | OP_ADD, 0, 0);
    for (int i = 0; i < 3; i++) cyc(MRD, 0, 0);
    cyc(MRD, 0, 1); cyc(MTR | RGW, 0, 0);
    // beq taken, bne not taken, bne taken
    instr(6'b000100, 6'b000000);
    cyc(FETCH_V, 0, 0); cyc('0, 0, 0); cyc(PSRC | PCW | OP_SUB, 1, 0);
    instr(6'b000101, 6'b000000);
    cyc(FETCH_V, 0, 0); cyc('0, 0, 0); cyc(OP_SUB, 1, 0);
    cyc(FETCH_V, 0, 0); cyc('0, 0, 0); cyc(PSRC | PCW | OP_SUB, 0, 0);
    // jal, jr, j
    instr(6'b000011, 6'b000000);
    cyc(FETCH_V, 0, 0); cyc('0, 0, 0); cyc(JMPB | PCW | RSEL | JALB | RGW, 0, 0);
    instr(6'b000000, 6'b001000);
    cyc(FETCH_V, 0, 0); cyc('0, 0, 0); cyc(JMPB | JRB | PCW, 0, 0);
    instr(6'b000010, 6'b000000);
    cyc(FETCH_V, 0, 0); cyc('0, 0, 0); cyc(JMPB | PCW, 0, 0);
    // sw that never sees mem_ready
    instr(6'b101011, 6'b000000);
    cyc(FETCH_V, 0, 0); cyc('0, 0, 0); cyc(ASRC | OP_ADD, 0, 0);
    for (int i = 0; i < 16; i++) cyc(MWR, 0, 0);
    // illegal opcode, then illegal funct
    instr(6'b111111, 6'b000000);
    cyc(FETCH_V | BERR, 0, 0); cyc(ILL, 0, 0);
    instr(6'b000000, 6'b000000);
    cyc(FETCH_V, 0, 0); cyc(ILL, 0, 0);
    // lw with ready on the timeout cycle: ready wins
    instr(6'b100011, 6'b000000);
    cyc(FETCH_V, 0, 0); cyc('0, 0, 0); cyc(ASRC | OP_ADD, 0, 0);
    for (int i = 0; i < 15; i++) cyc(MRD, 0, 0);
    cyc(MRD, 0, 1); cyc(MTR | RGW, 0, 0);
    // reset asserted between edges during MEM_RD
    cyc(FETCH_V, 0, 0); cyc('0, 0, 0); cyc(ASRC | OP_ADD, 0, 0); cyc(MRD, 0, 0);
    rst = 1'b0;
    #1;
    n_vec++;
    if (memread !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_memread: got %b want 0", memread);
    end
    cyc('0, 0, 0);
    rst = 1'b1;
    cyc('0, 0, 0);
    instr(6'b000000, 6'b100000);
    cyc(FETCH_V, 0, 0); cyc('0, 0, 0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
